// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: registered LEGv8 decode stage with NZCV register, load-use bubble, stall and flush
module id_stage_ctrl #(
    parameter int DATA_W         = 64,
    parameter int REG_AW         = 5,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              if_ready,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    input  logic              cbz_zero,
    output logic              id_valid,
    output logic [REG_AW-1:0] id_rd,
    output logic [REG_AW-1:0] id_rn,
    output logic [REG_AW-1:0] id_rm,
    output logic [DATA_W-1:0] id_imm,
    output logic [5:0]        id_shamt,
    output logic [2:0]        id_alu_op,
    output logic [8:0]        id_ctrl,
    output logic              id_br_taken,
    output logic              id_br_uncond,
    output logic              id_illegal,
    output logic [3:0]        flags_q
);
    localparam logic [REG_AW-1:0] REG_ZERO = '1;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rn;
        logic [REG_AW-1:0] rm;
        logic [DATA_W-1:0] imm;
        logic [5:0]        shamt;
        logic [2:0]        alu_op;
        logic [8:0]        ctrl;
        logic              br_taken;
        logic              br_uncond;
        logic              illegal;
    } id_t;
    id_t d, q;
    logic [10:0] op;
    logic [REG_AW-1:0] rd, rn, rm;
    logic [DATA_W-1:0] imm9, imm19, imm26;
    logic is_addi, is_subi, is_add, is_sub, is_adds, is_subs, is_and, is_orr, is_eor;
    logic is_lsl, is_lsr, is_ldur, is_stur, is_b, is_bcond, is_cbz, is_cbnz;
    logic is_imm, is_rr, is_sh, is_mem, is_cb, reads_rn;
    logic [3:0] f;
    logic [7:0] cv;
    logic cond_ok, hazard, stall, accept;
    assign op    = if_instr[31:21];
    assign rd    = REG_AW'(if_instr[4:0]);
    assign rn    = REG_AW'(if_instr[9:5]);
    assign rm    = REG_AW'(if_instr[20:16]);
    assign imm9  = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
    assign imm19 = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
    assign imm26 = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
    assign is_addi  = op[10:1] == 10'b1001000100;
    assign is_subi  = op[10:1] == 10'b1101000100;
    assign is_add   = op == 11'b10001011000;
    assign is_sub   = op == 11'b11001011000;
    assign is_adds  = op == 11'b10101011000;
    assign is_subs  = op == 11'b11101011000;
    assign is_and   = op == 11'b10001010000;
    assign is_orr   = op == 11'b10101010000;
    assign is_eor   = op == 11'b11001010000;
    assign is_lsl   = op == 11'b11010011011;
    assign is_lsr   = op == 11'b11010011010;
    assign is_ldur  = op == 11'b11111000010;
    assign is_stur  = op == 11'b11111000000;
    assign is_b     = op[10:5] == 6'b000101;
    assign is_bcond = op[10:3] == 8'b01010100;
    assign is_cbz   = op[10:3] == 8'b10110100;
    assign is_cbnz  = op[10:3] == 8'b10110101;
    assign is_imm   = is_addi | is_subi;
    assign is_rr    = is_add | is_sub | is_adds | is_subs | is_and | is_orr | is_eor;
    assign is_sh    = is_lsl | is_lsr;
    assign is_mem   = is_ldur | is_stur;
    assign is_cb    = is_cbz | is_cbnz;
    assign reads_rn = is_imm | is_rr | is_sh | is_mem;
    // Same-cycle flag write is forwarded so a B.cond right behind a flag-setter sees fresh NZCV
    assign f       = flags_we ? flags_in : flags_q;
    assign cv      = {1'b1, ~f[2] & (f[3] == f[0]), f[3] == f[0], f[1] & ~f[2], f[0], f[3], f[1], f[2]};
    assign cond_ok = cv[if_instr[3:1]] ^ (if_instr[0] & (if_instr[3:1] != 3'd7));
    assign hazard  = if_valid & q.valid & q.ctrl[3] & (q.rd != REG_ZERO) &
                     ((reads_rn & (rn == q.rd)) | (is_rr & (rm == q.rd)) | ((is_stur | is_cb) & (rd == q.rd)));
    assign stall    = LOAD_USE_STALL & hazard;
    assign if_ready = rst_n & ex_ready & ~stall;
    assign accept   = if_valid & if_ready;
    always_comb begin
        d = '0;
        d.valid = 1'b1;
        d.illegal = ~(is_imm | is_rr | is_sh | is_mem | is_b | is_bcond | is_cb);
        if (is_imm) begin
            d.rd = rd;
            d.rn = rn;
            d.imm = DATA_W'(if_instr[21:10]);
            d.alu_op = is_subi ? 3'b011 : 3'b010;
            d.ctrl = 9'b010100000;
        end
        if (is_rr) begin
            d.rd = rd;
            d.rn = rn;
            d.rm = rm;
            d.alu_op = is_and ? 3'b100 : is_orr ? 3'b101 : is_eor ? 3'b110 : (is_sub | is_subs) ? 3'b011 : 3'b010;
            d.ctrl = {6'b000100, is_adds | is_subs, 2'b00};
        end
        if (is_sh) begin
            d.rd = rd;
            d.rn = rn;
            d.shamt = if_instr[15:10];
            d.ctrl = {8'b00010001, is_lsl};
        end
        if (is_mem) begin
            d.rd = is_ldur ? rd : '0;
            d.rn = rn;
            d.rm = is_stur ? rd : '0;
            d.imm = imm9;
            d.alu_op = 3'b010;
            d.ctrl = is_ldur ? 9'b011101000 : 9'b110010000;
        end
        if (is_b) begin
            d.imm = imm26;
            d.br_taken = 1'b1;
            d.br_uncond = 1'b1;
        end
        if (is_bcond | is_cb) begin
            d.imm = imm19;
            d.br_taken = is_bcond ? cond_ok : is_cbz ? cbz_zero : ~cbz_zero;
            d.rm = is_cb ? rd : '0;
            d.ctrl = is_cb ? 9'b100000000 : 9'b000000000;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            flags_q <= '0;
        end else begin
            if (flags_we) flags_q <= flags_in;
            if (flush || (ex_ready && !accept)) q <= '0;
            else if (ex_ready) q <= d;
        end
    end
    assign {id_valid, id_rd, id_rn, id_rm, id_imm, id_shamt, id_alu_op, id_ctrl, id_br_taken, id_br_uncond, id_illegal} = q;
endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: directed vector table plus hand-written stall/hold/flush sequences
module tb_id_stage_ctrl;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [31:0] ADDI_X4 = 32'h91006024;
    logic clk, rst_n, if_valid, if_ready, ex_ready, flush, flags_we, cbz_zero;
    logic [31:0] if_instr;
    logic [3:0] flags_in, flags_q;
    logic id_valid, id_br_taken, id_br_uncond, id_illegal;
    logic [4:0] id_rd, id_rn, id_rm;
    logic [63:0] id_imm;
    logic [5:0] id_shamt;
    logic [2:0] id_alu_op;
    logic [8:0] id_ctrl;
    logic n_if_ready, n_id_valid, n_id_br_taken, n_id_br_uncond, n_id_illegal;
    logic [4:0] n_id_rd, n_id_rn, n_id_rm;
    logic [63:0] n_id_imm;
    logic [5:0] n_id_shamt;
    logic [2:0] n_id_alu_op;
    logic [8:0] n_id_ctrl;
    logic [3:0] n_flags_q;
    logic [100:0] act_b;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [31:0] instr;
        logic        fwe;
        logic [3:0]  fin;
        logic        cz;
        logic [4:0]  rd, rn, rm;
        logic [63:0] imm;
        logic [5:0]  sh;
        logic [2:0]  alu;
        logic [8:0]  ctrl;
        logic        t, u, il;
    } vec_t;
    vec_t vt[26];
    logic [31:0] hz_i[6];
    logic hz_r[6];
    logic [100:0] exp_subs;

    id_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .ex_ready(ex_ready), .flush(flush), .flags_we(flags_we), .flags_in(flags_in), .cbz_zero(cbz_zero),
        .id_valid(id_valid), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .id_br_taken(id_br_taken),
        .id_br_uncond(id_br_uncond), .id_illegal(id_illegal), .flags_q(flags_q)
    );
    id_stage_ctrl #(.LOAD_USE_STALL(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_ready(n_if_ready),
        .ex_ready(ex_ready), .flush(flush), .flags_we(flags_we), .flags_in(flags_in), .cbz_zero(cbz_zero),
        .id_valid(n_id_valid), .id_rd(n_id_rd), .id_rn(n_id_rn), .id_rm(n_id_rm), .id_imm(n_id_imm),
        .id_shamt(n_id_shamt), .id_alu_op(n_id_alu_op), .id_ctrl(n_id_ctrl), .id_br_taken(n_id_br_taken),
        .id_br_uncond(n_id_br_uncond), .id_illegal(n_id_illegal), .flags_q(n_flags_q)
    );

    assign act_b = {id_valid, id_rd, id_rn, id_rm, id_imm, id_shamt, id_alu_op, id_ctrl, id_br_taken, id_br_uncond, id_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [10:0] op, input int rm, input int sh, input int rn, input int rd);
        return {op, 5'(rm), 6'(sh), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] ii(input logic [9:0] op, input int imm, input int rn, input int rd);
        return {op, 12'(imm), 5'(rn), 5'(rd)};
    endfunction
    function automatic logic [31:0] dd(input logic [10:0] op, input int imm, input int rn, input int rt);
        return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
    endfunction
    function automatic logic [31:0] bb(input int imm);
        return {6'b000101, 26'(imm)};
    endfunction
    function automatic logic [31:0] cb(input logic [7:0] op, input int imm, input int rt);
        return {op, 19'(imm), 5'(rt)};
    endfunction
    function automatic logic [100:0] eb(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [63:0] imm, input logic [5:0] sh, input logic [2:0] alu,
                                        input logic [8:0] ctrl, input logic t, input logic u, input logic il);
        return {1'b1, rd, rn, rm, imm, sh, alu, ctrl, t, u, il};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{ADDI_X4, 1'b0, 4'h0, 1'b0, 5'd4, 5'd1, 5'd0, 64'd24, 6'd0, 3'b010, 9'b010100000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{ii(10'b1101000100, 4095, 6, 5), 1'b0, 4'h0, 1'b0, 5'd5, 5'd6, 5'd0, 64'd4095, 6'd0, 3'b011, 9'b010100000, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{rr(OP_ADD, 5, 0, 2, 3), 1'b0, 4'h0, 1'b0, 5'd3, 5'd2, 5'd5, 64'd0, 6'd0, 3'b010, 9'b000100000, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{rr(OP_SUBS, 9, 0, 8, 7), 1'b0, 4'h0, 1'b0, 5'd7, 5'd8, 5'd9, 64'd0, 6'd0, 3'b011, 9'b000100100, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{rr(11'b10101011000, 3, 0, 2, 1), 1'b0, 4'h0, 1'b0, 5'd1, 5'd2, 5'd3, 64'd0, 6'd0, 3'b010, 9'b000100100, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{rr(11'b10001010000, 12, 0, 11, 10), 1'b0, 4'h0, 1'b0, 5'd10, 5'd11, 5'd12, 64'd0, 6'd0, 3'b100, 9'b000100000, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{rr(11'b10101010000, 15, 0, 14, 13), 1'b0, 4'h0, 1'b0, 5'd13, 5'd14, 5'd15, 64'd0, 6'd0, 3'b101, 9'b000100000, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{rr(11'b11001010000, 18, 0, 17, 16), 1'b0, 4'h0, 1'b0, 5'd16, 5'd17, 5'd18, 64'd0, 6'd0, 3'b110, 9'b000100000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{rr(OP_LSL, 0, 5, 2, 1), 1'b0, 4'h0, 1'b0, 5'd1, 5'd2, 5'd0, 64'd0, 6'd5, 3'b000, 9'b000100011, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{rr(11'b11010011010, 0, 63, 4, 3), 1'b0, 4'h0, 1'b0, 5'd3, 5'd4, 5'd0, 64'd0, 6'd63, 3'b000, 9'b000100010, 1'b0, 1'b0, 1'b0};
        vt[10] = '{dd(OP_LDUR, -8, 1, 2), 1'b0, 4'h0, 1'b0, 5'd2, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 6'd0, 3'b010, 9'b011101000, 1'b0, 1'b0, 1'b0};
        vt[11] = '{dd(OP_STUR, 255, 3, 9), 1'b0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd9, 64'd255, 6'd0, 3'b010, 9'b110010000, 1'b0, 1'b0, 1'b0};
        vt[12] = '{bb(-1), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 3'b000, 9'd0, 1'b1, 1'b1, 1'b0};
        vt[13] = '{bb(33554431), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'h1FF_FFFF, 6'd0, 3'b000, 9'd0, 1'b1, 1'b1, 1'b0};
        vt[14] = '{cb(8'h54, 4, 0), 1'b1, 4'b0100, 1'b0, 5'd0, 5'd0, 5'd0, 64'd4, 6'd0, 3'b000, 9'd0, 1'b1, 1'b0, 1'b0};
        vt[15] = '{cb(8'h54, -2, 1), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE, 6'd0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b0};
        vt[16] = '{cb(8'h54, 1, 8), 1'b1, 4'b0010, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b1, 1'b0, 1'b0};
        vt[17] = '{cb(8'h54, 1, 9), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b0};
        vt[18] = '{cb(8'h54, 1, 10), 1'b1, 4'b1001, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b1, 1'b0, 1'b0};
        vt[19] = '{cb(8'h54, 1, 13), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b0};
        vt[20] = '{cb(8'h54, 1, 15), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b1, 1'b0, 1'b0};
        vt[21] = '{cb(8'h54, 1, 4), 1'b1, 4'b0111, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b0};
        vt[22] = '{cb(8'b10110100, 8, 3), 1'b0, 4'h0, 1'b1, 5'd0, 5'd0, 5'd3, 64'd8, 6'd0, 3'b000, 9'b100000000, 1'b1, 1'b0, 1'b0};
        vt[23] = '{cb(8'b10110101, 262143, 3), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd3, 64'h3FFFF, 6'd0, 3'b000, 9'b100000000, 1'b1, 1'b0, 1'b0};
        vt[24] = '{32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 6'd0, 3'b000, 9'd0, 1'b0, 1'b0, 1'b1};
        vt[25] = '{cb(8'h54, 1, 14), 1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd1, 6'd0, 3'b000, 9'd0, 1'b1, 1'b0, 1'b0};
        hz_i[0] = rr(OP_ADD, 2, 0, 5, 3);      hz_r[0] = 1'b0;
        hz_i[1] = dd(OP_STUR, 0, 1, 2);        hz_r[1] = 1'b0;
        hz_i[2] = cb(8'b10110101, 4, 2);       hz_r[2] = 1'b0;
        hz_i[3] = rr(OP_LSL, 0, 2, 6, 2);      hz_r[3] = 1'b1;
        hz_i[4] = bb(2);                       hz_r[4] = 1'b1;
        hz_i[5] = ii(OP_ADDI, 2, 1, 9);        hz_r[5] = 1'b1;
        exp_subs = eb(5'd7, 5'd8, 5'd9, 64'd0, 6'd0, 3'b011, 9'b000100100, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1; flush = 1'b0;
        flags_we = 1'b0; flags_in = '0; cbz_zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {act_b, if_ready, flags_q}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            if_valid = 1'b1; if_instr = vt[i].instr;
            flags_we = vt[i].fwe; flags_in = vt[i].fin; cbz_zero = vt[i].cz;
            step;
            chk($sformatf("vec%0d", i), act_b, eb(vt[i].rd, vt[i].rn, vt[i].rm, vt[i].imm, vt[i].sh,
                                                   vt[i].alu, vt[i].ctrl, vt[i].t, vt[i].u, vt[i].il));
        end
        flags_we = 1'b0;
        chk("flags_reg", flags_q, 4'b0111);

        #2 rst_n = 1'b0;
        #1 chk("mid_reset", {act_b, if_ready, flags_q}, '0);
        @(negedge clk);
        rst_n = 1'b1; if_instr = ADDI_X4;
        step;
        chk("post_reset_addi", act_b, eb(5'd4, 5'd1, 5'd0, 64'd24, 6'd0, 3'b010, 9'b010100000, 1'b0, 1'b0, 1'b0));

        if_instr = dd(OP_LDUR, 0, 1, 2);
        step;
        if_instr = rr(OP_ADD, 5, 0, 2, 3);
        #1 chk("lu_ready_low", if_ready, 1'b0);
        chk("lu_nostall_ready", n_if_ready, 1'b1);
        step;
        chk("lu_bubble", {id_valid, id_ctrl}, '0);
        chk("lu_ready_back", if_ready, 1'b1);
        step;
        chk("lu_add_issue", act_b, eb(5'd3, 5'd2, 5'd5, 64'd0, 6'd0, 3'b010, 9'b000100000, 1'b0, 1'b0, 1'b0));
        if_valid = 1'b0;
        step;
        chk("lu_drain", id_valid, 1'b0);

        if_valid = 1'b1; if_instr = dd(OP_LDUR, 0, 1, 31);
        step;
        if_instr = rr(OP_ADD, 5, 0, 31, 3);
        #1 chk("lu_x31_ready", if_ready, 1'b1);
        step;
        chk("lu_x31_issue", {id_valid, id_rd, id_rn}, {1'b1, 5'd3, 5'd31});

        for (int k = 0; k < 6; k++) begin
            if_valid = 1'b1; if_instr = dd(OP_LDUR, 0, 1, 2);
            step;
            if_instr = hz_i[k];
            #1 chk($sformatf("hazard%0d_ready", k), if_ready, hz_r[k]);
            if_valid = 1'b0;
            step;
        end

        if_valid = 1'b1; if_instr = 32'h5400020B; flags_we = 1'b1; flags_in = 4'b1000;
        step;
        chk("blt_fwd_taken", {id_br_taken, id_br_uncond, id_imm}, {1'b1, 1'b0, 64'd16});
        flags_in = 4'b1001;
        step;
        chk("blt_fwd_not_taken", id_br_taken, 1'b0);
        chk("flags_after_blt", flags_q, 4'b1001);
        flags_we = 1'b0;

        if_instr = rr(OP_SUBS, 9, 0, 8, 7);
        step;
        chk("hold_subs_in", act_b, exp_subs);
        ex_ready = 1'b0; if_instr = ADDI_X4;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("hold%0d_ready", k), if_ready, 1'b0);
            step;
            chk($sformatf("hold%0d_frozen", k), act_b, exp_subs);
        end
        ex_ready = 1'b1;
        step;
        chk("hold_release_addi", act_b, eb(5'd4, 5'd1, 5'd0, 64'd24, 6'd0, 3'b010, 9'b010100000, 1'b0, 1'b0, 1'b0));
        if_valid = 1'b0;
        step;
        chk("hold_no_dup", id_valid, 1'b0);

        if_valid = 1'b1; if_instr = dd(OP_LDUR, 0, 1, 2);
        step;
        if_instr = rr(OP_ADD, 5, 0, 2, 3); flush = 1'b1;
        #1 chk("flush_stall_ready", if_ready, 1'b0);
        step;
        chk("flush_bubble", id_valid, 1'b0);
        flush = 1'b0;
        #1 chk("flush_stall_cleared", if_ready, 1'b1);
        step;
        chk("flush_then_add", {id_valid, id_rd, id_rn, id_rm}, {1'b1, 5'd3, 5'd2, 5'd5});
        if_instr = ADDI_X4; flush = 1'b1;
        step;
        chk("flush_drops_accept", id_valid, 1'b0);
        flush = 1'b0; if_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
